// File: rtl/scr1_tb_ahb_pkg.sv
// Shared AHB encodings, slave FSM states and byte-enable decode for the
// testbench memory ports (imem and dmem instances).
package scr1_tb_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  function automatic logic [3:0] be_decode(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/scr1_tb_stall_gen.sv
// Rotating wait-state pattern; bit 0 says whether the current data cycle
// may complete.
module scr1_tb_stall_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_pattern,
  input  logic        i_rotate,
  output logic        o_ready_bit
);

  logic [31:0] r_pat;

  // A zero pattern would stall forever, so it is replaced by a single ready slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= 32'hFFFF_FFFF;
    end else if (i_load) begin
      r_pat <= (i_pattern == 32'h0) ? 32'h0000_0001 : i_pattern;
    end else if (i_rotate) begin
      r_pat <= {r_pat[0], r_pat[31:1]};
    end
  end

  assign o_ready_bit = r_pat[0];

endmodule

// File: rtl/scr1_tb_ahb_slave_port.sv
// AHB-Lite slave front-end: decodes/error-checks transfers, injects wait
// states and drives a single-access memory port with combinational read.
module scr1_tb_ahb_slave_port
  import scr1_tb_ahb_pkg::*;
#(
  parameter int AHB_WIDTH      = 32,
  parameter int MEM_POWER_SIZE = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               stall_pattern_in,
  input  logic                      pattern_wr,
  input  logic [2:0]                hsize,
  input  logic [1:0]                htrans,
  input  logic [AHB_WIDTH-1:0]      haddr,
  input  logic                      hwrite,
  input  logic [AHB_WIDTH-1:0]      hwdata,
  output logic                      hready,
  output logic [AHB_WIDTH-1:0]      hrdata,
  output logic                      hresp,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_POWER_SIZE-1:0] mem_addr,
  output logic [3:0]                mem_be,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
);

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic [MEM_POWER_SIZE-1:0] r_addr;
  logic [2:0]                r_size;
  logic                      r_write;
  logic [AHB_WIDTH-1:0]      r_hrdata;
  logic                      w_pat0;
  logic                      w_accept;
  logic                      w_oor;
  logic                      w_misalign;
  logic                      w_err;
  logic                      w_complete;

  scr1_tb_stall_gen u_stall_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (pattern_wr),
    .i_pattern   (stall_pattern_in),
    .i_rotate    (r_state == ST_DATA),
    .o_ready_bit (w_pat0)
  );

  always_comb begin
    case (r_state)
      ST_DATA: hready = w_pat0;
      ST_ERR1: hready = 1'b0;
      default: hready = 1'b1;
    endcase
  end

  assign hresp    = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign w_accept = htrans[1] & hready;
  assign w_oor    = |haddr[AHB_WIDTH-1:MEM_POWER_SIZE];

  always_comb begin
    case (hsize)
      HSIZE_HALF: w_misalign = haddr[0];
      HSIZE_WORD: w_misalign = |haddr[1:0];
      default:    w_misalign = 1'b0;
    endcase
  end

  assign w_err = w_oor | (hsize > HSIZE_WORD) | w_misalign;

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_ERR1) begin
      w_state_nxt = ST_ERR2;
    end else if (hready) begin
      if (w_accept) w_state_nxt = w_err ? ST_ERR1 : ST_DATA;
      else          w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Address-phase attributes carry into the data phase; they are only
  // observed while in DATA, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= haddr[MEM_POWER_SIZE-1:0];
      r_size  <= hsize;
      r_write <= hwrite;
    end
  end

  assign w_complete = (r_state == ST_DATA) & w_pat0;
  assign mem_req    = w_complete;
  assign mem_we     = w_complete & r_write;
  assign mem_addr   = {r_addr[MEM_POWER_SIZE-1:2], 2'b00};
  assign mem_wdata  = hwdata[31:0];

  always_comb begin
    mem_be = 4'b0000;
    if (w_complete) mem_be = r_write ? be_decode(r_size, r_addr[1:0]) : 4'b1111;
  end

  // Read data is live on the completing cycle, then held for the master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_hrdata <= '0;
    else if (w_complete && !r_write) r_hrdata <= mem_rdata;
  end

  assign hrdata = (w_complete && !r_write) ? mem_rdata : r_hrdata;

endmodule
